spi_flash_ctrl: RTL and testbench

- Register-mapped SPI master engine. Sits directly downstream of the picosoc flash-write iomem bridge.
- Consumes that bridge's level-held ctrl_wr/ctrl_rd requests and returns a one-cycle ctrl_done plus read data.
- Drives the external SPI flash pins: mode 0, MSB first, byte or 32-bit word transfers, software-controlled chip selects, programmable SCLK divider.

---
 rtl/spi_flash_pkg.sv | 33 +++
 rtl/spi_flash_ctrl_if.sv | 30 +++
 rtl/spi_shift_engine.sv | 81 ++++++++
 rtl/spi_flash_ctrl.sv | 116 +++++++++++
 tb/tb_spi_flash_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: shared constants and types for the SPI flash controller.
// Register map, FSM encoding and divider helpers.
package spi_flash_pkg;

   localparam int DIV_W = 16;

   localparam logic [7:0] ADDR_DATA8  = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_CS     = 8'h08;
   localparam logic [7:0] ADDR_DIV    = 8'h0C;
   localparam logic [7:0] ADDR_DATA32 = 8'h10;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOW  = 3'd1;
   localparam logic [2:0] ST_HIGH = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ACK  = 3'd4;

   typedef struct packed {
      logic        word;
      logic [31:0] data;
   } xfer_t;

   function automatic logic [DIV_W-1:0] div_init(
      input int unsigned clk_hz,
      input int unsigned spi_hz
   );
      int unsigned d;
      d = clk_hz / (2 * spi_hz) - 1;
      return d[DIV_W-1:0];
   endfunction

endpackage

// File: rtl/spi_flash_ctrl_if.sv
// spi_flash_ctrl_if: level-held request / one-cycle done register bus.
// The bridge is the master, the SPI engine the slave.
interface spi_flash_ctrl_if;

   logic        ctrl_wr;
   logic        ctrl_rd;
   logic [7:0]  ctrl_addr;
   logic [31:0] ctrl_wdat;
   logic [31:0] ctrl_rdat;
   logic        ctrl_done;

   modport master (
      output ctrl_wr,
      output ctrl_rd,
      output ctrl_addr,
      output ctrl_wdat,
      input  ctrl_rdat,
      input  ctrl_done
   );

   modport slave (
      input  ctrl_wr,
      input  ctrl_rd,
      input  ctrl_addr,
      input  ctrl_wdat,
      output ctrl_rdat,
      output ctrl_done
   );

endinterface

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: mode-0 MSB-first shifter with programmable half-period.
// Runs the LOW/HIGH phases of one 8- or 32-bit transfer per start pulse.
module spi_shift_engine
   import spi_flash_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  xfer_t            req,
   input  logic [DIV_W-1:0] div,
   input  logic             miso,
   output logic             sclk,
   output logic             mosi,
   output logic             busy,
   output logic             fin,
   output logic [31:0]      rx
);

   logic [2:0]       phase;
   logic [DIV_W-1:0] cnt;
   logic [4:0]       bits;
   logic [31:0]      sh;
   logic             tick;

   assign tick = (cnt == div);
   assign busy = (phase != ST_IDLE);
   assign fin  = (phase == ST_HIGH) && tick && (bits == 5'd0);

   // mosi is the head of the tx shifter, so it moves only on load or fall
   assign mosi = sh[31];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase <= ST_IDLE;
         cnt   <= '0;
         bits  <= '0;
         sh    <= '0;
         rx    <= '0;
         sclk  <= 1'b0;
      end else begin
         case (phase)
            ST_IDLE: begin
               if (start) begin
                  sh    <= req.word ? req.data
                                    : {req.data[7:0], 24'b0};
                  bits  <= req.word ? 5'd31 : 5'd7;
                  cnt   <= '0;
                  phase <= ST_LOW;
               end
            end
            ST_LOW: begin
               if (tick) begin
                  cnt   <= '0;
                  sclk  <= 1'b1;
                  rx    <= {rx[30:0], miso};
                  phase <= ST_HIGH;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            ST_HIGH: begin
               if (tick) begin
                  cnt  <= '0;
                  sclk <= 1'b0;
                  if (bits == 5'd0) begin
                     phase <= ST_IDLE;
                  end else begin
                     bits  <= bits - 5'd1;
                     sh    <= {sh[30:0], 1'b0};
                     phase <= ST_LOW;
                  end
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            default: phase <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/spi_flash_ctrl.sv
// spi_flash_ctrl: register-mapped SPI master behind the flash-write bridge.
// Decodes the register map and runs the request/done handshake.
module spi_flash_ctrl
   import spi_flash_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ_HZ = 16000000,
   parameter int unsigned SPI_FREQ_HZ   = 1000000,
   parameter int unsigned CS_LENGTH     = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   spi_flash_ctrl_if.slave      ctrl,
   output logic                 mosi,
   input  logic                 miso,
   output logic                 sclk,
   output logic [CS_LENGTH-1:0] cs
);

   localparam logic [DIV_W-1:0] DIV_RST =
      div_init(CLOCK_FREQ_HZ, SPI_FREQ_HZ);

   logic [2:0]           state;
   logic [DIV_W-1:0]     div_q;
   logic [CS_LENGTH-1:0] cs_q;
   logic                 hit_d8;
   logic                 hit_st;
   logic                 hit_cs;
   logic                 hit_div;
   logic                 hit_d32;
   logic                 start;
   logic                 busy;
   logic                 fin;
   logic [31:0]          rx;
   logic [31:0]          rd_mux;
   xfer_t                xfer;

   assign hit_d8  = (ctrl.ctrl_addr == ADDR_DATA8);
   assign hit_st  = (ctrl.ctrl_addr == ADDR_STATUS);
   assign hit_cs  = (ctrl.ctrl_addr == ADDR_CS);
   assign hit_div = (ctrl.ctrl_addr == ADDR_DIV);
   assign hit_d32 = (ctrl.ctrl_addr == ADDR_DATA32);

   // a write wins when both requests are up
   assign start = (state == ST_IDLE) && ctrl.ctrl_wr
                  && (hit_d8 || hit_d32);

   assign xfer = '{word: hit_d32, data: ctrl.ctrl_wdat};
   assign cs   = cs_q;

   always_comb begin
      rd_mux = '0;
      unique case (1'b1)
         hit_d8:  rd_mux = {24'b0, rx[7:0]};
         hit_st:  rd_mux = {31'b0, busy};
         hit_cs:  rd_mux = 32'(cs_q);
         hit_div: rd_mux = {{(32-DIV_W){1'b0}}, div_q};
         hit_d32: rd_mux = rx;
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         div_q          <= DIV_RST;
         cs_q           <= '1;
         ctrl.ctrl_done <= 1'b0;
         ctrl.ctrl_rdat <= '0;
      end else begin
         ctrl.ctrl_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (ctrl.ctrl_wr || ctrl.ctrl_rd) begin
                  if (start) begin
                     state <= ST_LOW;
                  end else begin
                     if (ctrl.ctrl_wr && hit_cs)
                        cs_q <= ctrl.ctrl_wdat[CS_LENGTH-1:0];
                     if (ctrl.ctrl_wr && hit_div)
                        div_q <= ctrl.ctrl_wdat[DIV_W-1:0];
                     ctrl.ctrl_rdat <= ctrl.ctrl_wr ? '0 : rd_mux;
                     ctrl.ctrl_done <= 1'b1;
                     state          <= ST_DONE;
                  end
               end
            end
            // the engine steps LOW/HIGH itself; wait for its final edge
            ST_LOW: begin
               if (fin) begin
                  ctrl.ctrl_rdat <= '0;
                  ctrl.ctrl_done <= 1'b1;
                  state          <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_ACK;
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   spi_shift_engine u_eng (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .req   (xfer),
      .div   (div_q),
      .miso  (miso),
      .sclk  (sclk),
      .mosi  (mosi),
      .busy  (busy),
      .fin   (fin),
      .rx    (rx)
   );

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// tb_spi_flash_ctrl: randomized register/transfer stimulus against a
// behavioural model of the register map, SPI waveform and rx history.
module tb_spi_flash_ctrl;
   import spi_flash_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       mosi;
   logic       miso;
   logic       sclk;
   logic [0:0] cs;

   spi_flash_ctrl_if bus ();

   spi_flash_ctrl #(
      .CLOCK_FREQ_HZ (16000000),
      .SPI_FREQ_HZ   (1000000),
      .CS_LENGTH     (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .ctrl  (bus),
      .mosi  (mosi),
      .miso  (miso),
      .sclk  (sclk),
      .cs    (cs)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [15:0] div_m;
   logic        cs_m;
   logic [31:0] rx_m;
   bit          loop_m = 1'b0;
   logic [31:0] slv_sh = '0;
   int          pulses = 0;
   int          width_err = 0;
   int          dones = 0;
   int          ops = 0;
   logic [31:0] cap = '0;
   int          run = 0;
   logic        prev_s = 1'b0;

   // flash model: loop-back or a pattern shifted out after each rise
   assign miso = loop_m ? mosi : slv_sh[31];

   always @(posedge sclk) slv_sh = {slv_sh[30:0], 1'b0};

   always @(negedge clk) begin
      if (reset) begin
         prev_s = 1'b0;
         run    = 0;
      end else begin
         if (sclk !== prev_s) begin
            if (sclk) begin
               pulses++;
               cap = {cap[30:0], mosi};
               if (pulses > 1 && run != div_m + 1) width_err++;
            end else if (run != div_m + 1) begin
               width_err++;
            end
            run    = 1;
            prev_s = sclk;
         end else begin
            run++;
         end
         if (bus.ctrl_done === 1'b1) dones++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // bridge behaviour: hold the request through done and one more cycle
   task automatic op(input bit wr, input bit rd, input logic [7:0] addr,
                     input logic [31:0] wdat, input int exp_lat,
                     output logic [31:0] rdat);
      int cyc;
      bus.ctrl_wr   = wr;
      bus.ctrl_rd   = rd;
      bus.ctrl_addr = addr;
      bus.ctrl_wdat = wdat;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.ctrl_done !== 1'b1 && cyc < 20000);
      chk("latency", cyc + 1, exp_lat);
      rdat = bus.ctrl_rdat;
      if (bus.ctrl_done === 1'b1) ops++;
      @(negedge clk);
      chk("done_width", {31'b0, bus.ctrl_done}, 0);
      @(negedge clk);
      bus.ctrl_wr = 1'b0;
      bus.ctrl_rd = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd(input logic [7:0] addr, input logic [31:0] exp,
                     input string tag);
      logic [31:0] r;
      op(1'b0, 1'b1, addr, $urandom, 2, r);
      chk(tag, r, exp);
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      logic [31:0] r;
      op(1'b1, 1'($urandom_range(0, 1)), addr, data, 2, r);
   endtask

   task automatic xfer(input bit word, input logic [31:0] tx,
                       input bit loop, input logic [31:0] pat);
      logic [31:0] r;
      logic [31:0] txm;
      logic [31:0] rcv;
      logic [31:0] capm;
      int          n;
      string       tag;
      n    = word ? 32 : 8;
      tag  = word ? "mosi32" : "mosi8";
      txm  = word ? tx : {24'b0, tx[7:0]};
      rcv  = loop ? txm : (word ? pat : {24'b0, pat[7:0]});
      loop_m    = loop;
      slv_sh    = word ? pat : {pat[7:0], 24'b0};
      pulses    = 0;
      width_err = 0;
      cap       = '0;
      op(1'b1, 1'($urandom_range(0, 1)),
         word ? ADDR_DATA32 : ADDR_DATA8, tx,
         2 * n * (int'(div_m) + 1) + 2, r);
      capm = word ? cap : {24'b0, cap[7:0]};
      chk(tag, capm, txm);
      chk("pulses", pulses, n);
      chk("sclk_width", width_err, 0);
      chk("sclk_idle", {31'b0, sclk}, 0);
      rx_m = word ? rcv : {rx_m[23:0], rcv[7:0]};
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] w;
      logic [7:0]  a;
      int          n;
      int          kind;

      bus.ctrl_wr   = 1'b0;
      bus.ctrl_rd   = 1'b0;
      bus.ctrl_addr = '0;
      bus.ctrl_wdat = '0;
      reset = 1'b1;
      div_m = 16'd7;
      cs_m  = 1'b1;
      rx_m  = '0;
      repeat (3) @(negedge clk);
      chk("rst_cs", 32'(cs), 1);
      chk("rst_sclk", {31'b0, sclk}, 0);
      chk("rst_mosi", {31'b0, mosi}, 0);
      chk("rst_done", {31'b0, bus.ctrl_done}, 0);
      chk("rst_rdat", bus.ctrl_rdat, 0);
      reset = 1'b0;
      @(negedge clk);
      rd(ADDR_DIV, 32'd7, "rst_div");

      wr(ADDR_CS, 32'h0);
      cs_m = 1'b0;
      chk("cs_pin", 32'(cs), 0);
      rd(ADDR_CS, 32'h0, "cs_rd");
      xfer(1'b0, 32'hA5, 1'b0, 32'h3C);
      rd(ADDR_DATA8, 32'h3C, "rx8");

      wr(ADDR_DIV, 32'h0);
      div_m = 16'd0;
      xfer(1'b1, 32'hDEADBEEF, 1'b1, 32'h0);
      rd(ADDR_DATA32, 32'hDEADBEEF, "rx32");

      pulses = 0;
      w = dones;
      repeat (40) @(negedge clk);
      chk("no_extra_xfer", pulses, 0);
      chk("no_extra_done", dones, w);
      rd(8'h20, 32'h0, "unmapped");
      rd(ADDR_STATUS, 32'h0, "status");

      wr(ADDR_DIV, 32'd7);
      div_m  = 16'd7;
      pulses = 0;
      bus.ctrl_wr   = 1'b1;
      bus.ctrl_addr = ADDR_DATA8;
      bus.ctrl_wdat = $urandom;
      n = 0;
      while (!(pulses == 3 && sclk === 1'b1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("mid_reach", {31'b0, n < 500}, 1);
      #2 reset = 1'b1;
      #1;
      chk("abort_sclk", {31'b0, sclk}, 0);
      chk("abort_cs", 32'(cs), 1);
      chk("abort_done", {31'b0, bus.ctrl_done}, 0);
      bus.ctrl_wr = 1'b0;
      w = dones;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      cs_m  = 1'b1;
      div_m = 16'd7;
      rx_m  = '0;
      repeat (30) @(negedge clk);
      chk("abort_no_done", dones, w);
      rd(ADDR_DIV, 32'd7, "div_after_rst");
      rd(ADDR_DATA8, 32'h0, "rx_after_rst");
      xfer(1'b0, $urandom, 1'b0, $urandom);

      for (int i = 0; i < 24; i++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0: begin
               w = $urandom;
               wr(ADDR_CS, w);
               cs_m = w[0];
               chk("cs_pin", 32'(cs), {31'b0, cs_m});
            end
            1: begin
               w = {16'($urandom), 16'($urandom_range(0, 3))};
               wr(ADDR_DIV, w);
               div_m = w[15:0];
            end
            2, 3: xfer(1'b0, $urandom, 1'($urandom_range(0, 1)),
                       $urandom);
            4: xfer(1'b1, $urandom, 1'($urandom_range(0, 1)),
                    $urandom);
            5: rd(ADDR_DATA8, {24'b0, rx_m[7:0]}, "rd_data8");
            6: rd(ADDR_DATA32, rx_m, "rd_data32");
            7: rd(ADDR_STATUS, 32'h0, "rd_status");
            8: begin
               rd(ADDR_CS, {31'b0, cs_m}, "rd_cs");
               rd(ADDR_DIV, {16'b0, div_m}, "rd_div");
            end
            default: begin
               a = 8'($urandom_range(0, 255));
               if (a == ADDR_DATA8 || a == ADDR_STATUS || a == ADDR_CS
                   || a == ADDR_DIV || a == ADDR_DATA32)
                  a = 8'h44;
               if ($urandom_range(0, 1) == 1) wr(a, $urandom);
               else rd(a, 32'h0, "rd_unmapped");
            end
         endcase
      end

      rd(ADDR_CS, {31'b0, cs_m}, "final_cs");
      rd(ADDR_DIV, {16'b0, div_m}, "final_div");
      chk("done_count", dones, ops);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
